// File: rtl/mem_access_unit_if.sv
// Data-bus request/response bundle between the memory access unit and the bus.
// master = access unit (drives the request), slave = bus side.
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  logic                    dreq_valid;
  logic [ADDR_WIDTH-1:0]   dreq_addr;
  logic [2:0]              dreq_size;
  logic [DATA_WIDTH/8-1:0] dreq_strobe;
  logic [DATA_WIDTH-1:0]   dreq_data;
  logic                    dresp_data_ok;
  logic [DATA_WIDTH-1:0]   dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_data_ok, dresp_data
  );
  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: lane-aligns store data, extracts and extends load data, IDLE/WAIT/DONE handshake.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned accesses fault instead of being force-aligned.
module mem_access_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  req_en,
  input  logic [3:0]            mem_op,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wd_in,
  mem_access_unit_if.master     bus,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  stall_this_dbus,
  output logic                  misalign_out
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int OW = $clog2(SW);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  misalign_q, misalign_d;
  logic [3:0]            op_q, op_d;
  logic [OW-1:0]         off_q, off_d;

  logic [1:0]            size;
  logic [OW-1:0]         raw_off, low_mask, off;
  logic                  size_bad, legal, req_v;

  assign size     = mem_op[1:0];
  assign raw_off  = addr_in[OW-1:0];
  assign low_mask = OW'((32'd1 << size) - 32'd1);
  assign size_bad = (DATA_WIDTH == 32) && (size == 2'd3);

`ifdef MEM_MISALIGN_TRAP_EN
  logic unaligned;
  assign unaligned = |(raw_off & low_mask);
  assign off       = raw_off;
  assign legal     = !size_bad && !unaligned;
`else
  // Misaligned addresses are silently rounded down to the access size.
  assign off   = raw_off & ~low_mask;
  assign legal = !size_bad;
`endif

  logic [SW-1:0] byte_mask;
  assign byte_mask = ~({SW{1'b1}} << (32'd1 << size));

  assign req_v            = reset && req_en && (state_q != DONE) && legal;
  assign bus.dreq_valid   = req_v;
  assign stall_this_dbus  = req_v;
  assign bus.dreq_addr    = addr_in;
  assign bus.dreq_size    = {1'b0, size};
  assign bus.dreq_strobe  = mem_op[3] ? (byte_mask << off) : '0;
  assign bus.dreq_data    = wd_in << {off, 3'b000};

  // In WAIT the request inputs may have dropped, so use the op captured at issue.
  logic [3:0]            lop;
  logic [OW-1:0]         loff;
  logic [DATA_WIDTH-1:0] shifted, lmask, ext;
  assign lop  = (state_q == WAIT) ? op_q  : mem_op;
  assign loff = (state_q == WAIT) ? off_q : off;

  always_comb begin
    shifted = bus.dresp_data >> {loff, 3'b000};
    lmask   = ~({DATA_WIDTH{1'b1}} << (32'd8 << lop[1:0]));
    ext     = shifted & lmask;
    if (!lop[2] && |(shifted & lmask & ~(lmask >> 1))) ext = ext | ~lmask;
  end

  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    op_d       = op_q;
    off_d      = off_q;
    unique case (state_q)
      IDLE: if (req_en) begin
        if (!legal) begin
          state_d    = DONE;
          misalign_d = 1'b1;
        end else begin
          op_d  = mem_op;
          off_d = off;
          if (bus.dresp_data_ok) begin
            state_d = DONE;
            if (!mem_op[3]) rdata_d = ext;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: if (bus.dresp_data_ok) begin
        state_d = DONE;
        if (!op_q[3]) rdata_d = ext;
      end
      DONE: if (!stall) begin
        state_d    = IDLE;
        misalign_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      op_q       <= '0;
      off_q      <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      op_q       <= op_d;
      off_q      <= off_d;
    end
  end

  assign rdata_out    = rdata_q;
  assign misalign_out = misalign_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Random + directed bench for mem_access_unit (DATA_WIDTH=64) against a transaction-level model.
module tb_mem_access_unit;
  localparam int DW = 64;
  localparam int AW = 64;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int P_IDLE = 0, P_WAIT = 1, P_DONE = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          req_en = 1'b0;
  logic [3:0]    mem_op = '0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] wd_in = '0;
  logic [DW-1:0] rdata_out;
  logic          stall_this_dbus, misalign_out;

  mem_access_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .req_en(req_en), .mem_op(mem_op),
    .addr_in(addr_in), .wd_in(wd_in), .bus(bus), .rdata_out(rdata_out),
    .stall_this_dbus(stall_this_dbus), .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- reference model: byte-lane arithmetic from the access rules ----
  function automatic bit legal_f(input logic [3:0] op, input logic [63:0] a);
    int bytes = 1 << op[1:0];
    return TRAP ? ((a % bytes) == 0) : 1'b1;
  endfunction

  function automatic int eoff_f(input logic [3:0] op, input logic [63:0] a);
    int off = int'(a[2:0]);
    int bytes = 1 << op[1:0];
    return TRAP ? off : off - (off % bytes);
  endfunction

  function automatic logic [7:0] strobe_f(input logic [3:0] op, input logic [63:0] a);
    int bytes = 1 << op[1:0];
    return op[3] ? 8'(((1 << bytes) - 1) << eoff_f(op, a)) : 8'h00;
  endfunction

  function automatic logic [63:0] load_f(input logic [3:0] op, input logic [63:0] a, input logic [63:0] d);
    int bits = 8 << op[1:0];
    logic [63:0] v = d >> (8 * eoff_f(op, a));
    logic [63:0] m = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
    v = v & m;
    if (!op[2] && v[bits-1]) v = v | ~m;
    return v;
  endfunction

  int          m_phase = P_IDLE;
  logic [3:0]  m_op = '0;
  logic [63:0] m_addr = '0;
  logic [63:0] m_rdata = '0;
  logic        m_mis = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= P_IDLE; m_rdata <= '0; m_mis <= 1'b0;
    end else if (m_phase == P_IDLE) begin
      if (req_en) begin
        if (!legal_f(mem_op, addr_in)) begin
          m_phase <= P_DONE; m_mis <= 1'b1;
        end else if (bus.dresp_data_ok) begin
          m_phase <= P_DONE;
          if (!mem_op[3]) m_rdata <= load_f(mem_op, addr_in, bus.dresp_data);
        end else begin
          m_phase <= P_WAIT; m_op <= mem_op; m_addr <= addr_in;
        end
      end
    end else if (m_phase == P_WAIT) begin
      if (bus.dresp_data_ok) begin
        m_phase <= P_DONE;
        if (!m_op[3]) m_rdata <= load_f(m_op, m_addr, bus.dresp_data);
      end
    end else if (!stall) begin
      m_phase <= P_IDLE; m_mis <= 1'b0;
    end
  end

  // ---- per-cycle compare ----
  always @(negedge clk) begin
    logic exp_v;
    exp_v = reset && req_en && (m_phase != P_DONE) && legal_f(mem_op, addr_in);
    chk("dreq_valid", 64'(bus.dreq_valid), 64'(exp_v));
    chk("stall_this_dbus", 64'(stall_this_dbus), 64'(exp_v));
    if (exp_v) begin
      chk("dreq_addr", bus.dreq_addr, addr_in);
      chk("dreq_size", 64'(bus.dreq_size), 64'(mem_op[1:0]));
      chk("dreq_strobe", 64'(bus.dreq_strobe), 64'(strobe_f(mem_op, addr_in)));
      chk("dreq_data", bus.dreq_data, wd_in << (8 * eoff_f(mem_op, addr_in)));
    end
    chk("rdata_out", rdata_out, m_rdata);
    chk("misalign_out", 64'(misalign_out), 64'(m_mis));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rand_txn();
    int dly;
    logic [63:0] a;
    mem_op  = 4'($urandom);
    a       = {$urandom, $urandom};
    if ($urandom_range(0, 1) != 0) a[2:0] = a[2:0] & ~3'((1 << mem_op[1:0]) - 1);
    addr_in = a;
    wd_in   = {$urandom, $urandom};
    bus.dresp_data = {$urandom, $urandom};
    dly = $urandom_range(0, 3);
    req_en = 1'b1;
    begin : issue
      for (int c = 0; c < 20; c++) begin
        if (m_phase == P_DONE) disable issue;
        if (c > 0) req_en = ($urandom_range(0, 5) != 0);
        bus.dresp_data_ok = (c >= dly);
        step();
      end
    end
    if (m_phase != P_DONE) begin
      n_vec++; n_bad++;
      $display("FAIL txn_timeout: transaction did not complete within 20 cycles");
    end
    bus.dresp_data_ok = ($urandom_range(0, 1) != 0);
    bus.dresp_data    = {$urandom, $urandom};
    req_en = ($urandom_range(0, 1) != 0);
    stall  = 1'b1;
    for (int s = $urandom_range(0, 2); s > 0; s--) step();
    stall  = 1'b0;
    step();
    req_en = 1'b0;
    bus.dresp_data_ok = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 1) != 0) step();
    bus.dresp_data_ok = 1'b0;
  endtask

  initial begin
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data    = '0;
    // reset state, with a request pending to show it is masked
    req_en = 1'b1; mem_op = 4'b0010; addr_in = 64'h40;
    step(); step();
    chk("reset_valid", 64'(bus.dreq_valid), 64'd0);
    chk("reset_rdata", rdata_out, 64'd0);
    chk("reset_mis", 64'(misalign_out), 64'd0);
    req_en = 1'b0;
    reset = 1'b1;
    step();

    // LB at ...03, single-cycle response
    req_en = 1'b1; mem_op = 4'b0000; addr_in = 64'h1003;
    bus.dresp_data = 64'h00000000_80000000; bus.dresp_data_ok = 1'b1;
    step();
    chk("lb_rdata", rdata_out, 64'hFFFFFFFF_FFFFFF80);
    req_en = 1'b0; bus.dresp_data_ok = 1'b0; step();

    // LHU at ...06
    req_en = 1'b1; mem_op = 4'b0101; addr_in = 64'h1006;
    bus.dresp_data = 64'hBEEF0000_00000000; bus.dresp_data_ok = 1'b1;
    step();
    chk("lhu_rdata", rdata_out, 64'h00000000_0000BEEF);
    req_en = 1'b0; bus.dresp_data_ok = 1'b0; step();

    // SW at ...04, three wait cycles
    req_en = 1'b1; mem_op = 4'b1010; addr_in = 64'h1004; wd_in = 64'h12345678;
    #1;
    chk("sw_strobe", 64'(bus.dreq_strobe), 64'hF0);
    chk("sw_data", bus.dreq_data, 64'h12345678_00000000);
    step(); step(); step();
    chk("sw_wait_stall", 64'(stall_this_dbus), 64'd1);
    bus.dresp_data = 64'hFFFF_FFFF_FFFF_FFFF; bus.dresp_data_ok = 1'b1;
    step();
    chk("sw_done_valid", 64'(bus.dreq_valid), 64'd0);
    chk("sw_rdata_kept", rdata_out, 64'h00000000_0000BEEF);
    req_en = 1'b0; bus.dresp_data_ok = 1'b0; step();

    // SD then stall held two cycles in DONE with req_en still high
    req_en = 1'b1; mem_op = 4'b1011; addr_in = 64'h2000; wd_in = 64'hA5A5_5A5A_0F0F_F0F0;
    bus.dresp_data_ok = 1'b1;
    #1 chk("sd_strobe", 64'(bus.dreq_strobe), 64'hFF);
    step();
    bus.dresp_data_ok = 1'b0; stall = 1'b1;
    #1 chk("sd_stall_valid0", 64'(bus.dreq_valid), 64'd0);
    step(); chk("sd_stall_valid1", 64'(bus.dreq_valid), 64'd0);
    step(); chk("sd_stall_valid2", 64'(bus.dreq_valid), 64'd0);
    stall = 1'b0; req_en = 1'b0; step();

    // LW at ...02
    req_en = 1'b1; mem_op = 4'b0010; addr_in = 64'h1002;
    bus.dresp_data = 64'h11111111_76543210; bus.dresp_data_ok = 1'b1;
    #1;
    if (TRAP) begin
      chk("lw_mis_valid", 64'(bus.dreq_valid), 64'd0);
      step();
      chk("lw_mis_flag", 64'(misalign_out), 64'd1);
      req_en = 1'b0; bus.dresp_data_ok = 1'b0; step();
      chk("lw_mis_clear", 64'(misalign_out), 64'd0);
    end else begin
      chk("lw_na_valid", 64'(bus.dreq_valid), 64'd1);
      chk("lw_na_strobe", 64'(bus.dreq_strobe), 64'h00);
      step();
      chk("lw_na_rdata", rdata_out, 64'h00000000_76543210);
      req_en = 1'b0; bus.dresp_data_ok = 1'b0; step();
    end

    // reset pulsed in WAIT; late response afterwards must be dropped
    req_en = 1'b1; mem_op = 4'b0110; addr_in = 64'h3000;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_wait_valid", 64'(bus.dreq_valid), 64'd0);
    chk("rst_wait_rdata", rdata_out, 64'd0);
    step(); step();
    reset = 1'b1; req_en = 1'b0;
    bus.dresp_data = 64'hDEAD_BEEF_CAFE_F00D; bus.dresp_data_ok = 1'b1;
    step();
    chk("rst_late_rdata", rdata_out, 64'd0);
    bus.dresp_data_ok = 1'b0; step();

    for (int t = 0; t < 300; t++) rand_txn();

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
